// File: rtl/vending_arbiter.sv
// Round-robin front end sharing one mini_vending datapath between N_REQ requesters.
// Optional macro VEND_CHK_EN adds a change-consistency checker (chk_err, chk_cnt).
module vending_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 6,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] money_in,
  input  logic [N_REQ*DW-1:0] bev_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       change_out,
  output logic                err,
  output logic                vm_en,
  output logic [DW-1:0]       vm_money,
  output logic [DW-1:0]       vm_beverage,
  input  logic [DW-1:0]       vm_change,
  input  logic                vm_finish
`ifdef VEND_CHK_EN
  ,
  output logic                chk_err,
  output logic [DW-1:0]       chk_cnt
`endif
);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, BEV, WAIT, DONE} state_t;

  state_t           state, state_d;
  logic [PW-1:0]    rr_ptr, rr_ptr_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [DW-1:0]    money_q, money_d;
  logic [DW-1:0]    bev_q, bev_d;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic [DW-1:0]    change_d, vm_money_d, vm_bev_d;
  logic             err_d, vm_en_d;
`ifdef VEND_CHK_EN
  logic             chk_err_d;
  logic [DW-1:0]    chk_cnt_d;
`endif

  logic [N_REQ-1:0] cand;
  logic             pick_vld;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    pick_next;
  logic [N_REQ-1:0] pick_oh;
  logic [DW-1:0]    pick_money, pick_bev;
  int unsigned      scan;

  // Round-robin scan from rr_ptr; in DONE the finishing requester is masked as its req may still be high.
  always_comb begin
    cand     = (state == DONE) ? (req & ~gnt) : req;
    pick_vld = 1'b0;
    pick     = '0;
    scan     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = 32'(rr_ptr) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      if (!pick_vld && cand[PW'(scan)]) begin
        pick_vld = 1'b1;
        pick     = PW'(scan);
      end
    end
    pick_oh    = N_REQ'(1) << pick;
    pick_money = money_in[32'(pick)*DW +: DW];
    pick_bev   = bev_in[32'(pick)*DW +: DW];
    pick_next  = (32'(pick) == N_REQ - 1) ? '0 : PW'(32'(pick) + 1);
  end

  // Next state and next registered outputs; DONE arbitrates directly to keep 4 cycles per transaction.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    cnt_d      = cnt;
    money_d    = money_q;
    bev_d      = bev_q;
    gnt_d      = gnt;
    done_d     = '0;
    change_d   = '0;
    err_d      = 1'b0;
    vm_en_d    = 1'b0;
    vm_money_d = '0;
    vm_bev_d   = '0;
`ifdef VEND_CHK_EN
    chk_err_d  = 1'b0;
    chk_cnt_d  = chk_cnt;
`endif
    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        if (pick_vld) begin
          gnt_d    = pick_oh;
          rr_ptr_d = pick_next;
          money_d  = pick_money;
          bev_d    = pick_bev;
          if (pick_bev > pick_money) begin
            state_d  = DONE;
            done_d   = pick_oh;
            change_d = pick_money;
            err_d    = 1'b1;
          end else begin
            state_d    = LOAD;
            vm_en_d    = 1'b1;
            vm_money_d = pick_money;
          end
        end
      end
      LOAD: begin
        vm_bev_d = bev_q;
        state_d  = BEV;
      end
      BEV: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (vm_finish) begin
          state_d  = DONE;
          done_d   = gnt;
          change_d = vm_change;
`ifdef VEND_CHK_EN
          if (vm_change != DW'(money_q - bev_q)) begin
            chk_err_d = 1'b1;
            if (chk_cnt != '1) chk_cnt_d = chk_cnt + DW'(1);
          end
`endif
        end else begin
          cnt_d = cnt + CW'(1);
          if (cnt == CW'(TIMEOUT - 1)) begin
            state_d = DONE;
            done_d  = gnt;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      money_q     <= '0;
      bev_q       <= '0;
      gnt         <= '0;
      done        <= '0;
      change_out  <= '0;
      err         <= 1'b0;
      vm_en       <= 1'b0;
      vm_money    <= '0;
      vm_beverage <= '0;
`ifdef VEND_CHK_EN
      chk_err     <= 1'b0;
      chk_cnt     <= '0;
`endif
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      cnt         <= cnt_d;
      money_q     <= money_d;
      bev_q       <= bev_d;
      gnt         <= gnt_d;
      done        <= done_d;
      change_out  <= change_d;
      err         <= err_d;
      vm_en       <= vm_en_d;
      vm_money    <= vm_money_d;
      vm_beverage <= vm_bev_d;
`ifdef VEND_CHK_EN
      chk_err     <= chk_err_d;
      chk_cnt     <= chk_cnt_d;
`endif
    end
  end

endmodule

// File: doc/vending_arbiter.md
Name: vending_arbiter

Overview:
- Shares one mini_vending datapath between N_REQ independent requesters (coin slots).
- Arbitrates round-robin and sequences the datapath's two-phase protocol: en+money in one cycle, beverage in the next.
- Captures change on finish and returns it to the granted requester with a done pulse.
- Sits directly in front of mini_vending; each requester sees a simple req/done handshake.

Parameters:
- N_REQ, 4, number of requesters.
- DW, 6, money/beverage/change width.
- TIMEOUT, 4, max cycles spent in WAIT for vm_finish before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req  in  N_REQ  per-requester request; level, held until own done.
- money_in  in  N_REQ*DW  requester i money at bits [i*DW +: DW].
- bev_in  in  N_REQ*DW  requester i beverage price, same packing.
- gnt  out  N_REQ  one-hot grant, registered.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- change_out  out  DW  change for the completing requester; valid only while done is nonzero.
- err  out  1  valid with done: 1 = rejected or timed out.
- vm_en  out  1  to mini_vending en.
- vm_money  out  DW  to mini_vending money.
- vm_beverage  out  DW  to mini_vending beverage.
- vm_change  in  DW  from mini_vending change.
- vm_finish  in  1  from mini_vending finish.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low. rst==0 at an edge forces the following, regardless of state (including mid-transaction):
  - state=IDLE, rr_ptr=0, timeout counter=0, latched money/bev=0.
  - All outputs 0.
  - The aborted requester gets no done.
- All outputs are registered.
- States: IDLE, LOAD, BEV, WAIT, DONE.
- IDLE:
  - If req is all zero, stay in IDLE.
  - Otherwise pick the first set req at or after rr_ptr, wrapping modulo N_REQ. Call it g.
  - Set gnt=onehot(g) and latch money_in[g] and bev_in[g]. Set rr_ptr=(g+1) mod N_REQ.
  - If latched bev > money: go to DONE with change_out=money, err=1. The datapath is not touched.
  - Else go to LOAD with vm_en=1, vm_money=money.
- LOAD (one cycle): drive vm_en=0, vm_money=0, vm_beverage=bev; go to BEV.
- BEV (one cycle): drive vm_beverage=0; clear the timeout counter; go to WAIT.
- WAIT:
  - If vm_finish==1 at the edge, capture change_out=vm_change, err=0, and go to DONE.
  - Else increment the counter. When the counter reaches TIMEOUT, go to DONE with change_out=0, err=1.
- DONE (one cycle): done[g]=1 and change_out/err valid. At the next edge clear done, gnt, change_out and err, then go to IDLE.
- Timing from IDLE sampling req at edge k:
  - vm_en high in cycle k..k+1.
  - vm_beverage valid k+1..k+2.
  - vm_finish sampled at edge k+3; done high k+3..k+4.
  - Next grant no earlier than edge k+4, giving 4 cycles/transaction for back-to-back requests.
- Boundary cases:
  - req dropped by the granted requester mid-transaction: ignored; the transaction completes and done still pulses.
  - req from another requester during a transaction: held off until IDLE.
  - bev==money: legal; expected change 0.
  - money=0 with bev=0: legal, goes through the datapath.
  - rr_ptr wraps N_REQ-1 to 0.
  - vm_finish asserted outside WAIT: ignored.
  - The vm_* drive values are 0 whenever not in LOAD/BEV as listed above.
- Arithmetic: the price comparison is unsigned DW-bit. The arbiter never computes change itself; without VEND_CHK_EN it forwards vm_change unmodified.

Optional Feature:
- Macro: VEND_CHK_EN.
- When defined:
  - Adds output chk_err (1 bit, registered, reset 0).
  - In WAIT on vm_finish, compare vm_change against (money - bev) mod 2^DW.
  - On mismatch, chk_err=1 for the DONE cycle. change_out still carries vm_change.
  - Also adds a DW-bit saturating mismatch counter, output chk_cnt, cleared by reset.
- When not defined: the chk_err and chk_cnt ports and logic do not exist, and behaviour is otherwise identical.

Test Plan:
1. Single requester: req[0]=1, money=40, bev=35; datapath model returns 5 at finish. Expect the following, then gnt cleared and IDLE:
   - vm_en=1/vm_money=40 for one cycle, then vm_beverage=35 for one cycle.
   - done[0] pulse at edge k+3, change_out=5, err=0.
2. Round-robin: req=4'b1111, each requester's money-bev yields 15, 3, 5, 13. Expect:
   - Grants in order 0,1,2,3, each done carrying its own change.
   - Done pulses 4 cycles apart.
   - After a second round with req=4'b1001: grant order 0 then 3.
3. Reject: money=20, bev=52. Expect done in the cycle after the grant, change_out=20, err=1, vm_en never asserted.
4. Timeout: datapath model never raises finish, TIMEOUT=4. Expect done with err=1, change_out=0 exactly 4 cycles after entering WAIT; the next requester is then served normally.
5. Reset mid-operation: rst=0 during BEV. Expect all outputs 0 at the next edge, no done; after release, req=4'b0100 is granted first via rr_ptr=0 scan.
6. VEND_CHK_EN: money=63, bev=58, model returns 6. Expect change_out=6, chk_err=1, chk_cnt=1. A correct return of 5 next gives chk_err=0, chk_cnt still 1.
